// File: rtl/mem_copy_dma_if.sv
// RAM-side bus between mem_copy_dma (master) and the single-port synchronous RAM (slave).
interface mem_copy_dma_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              mem_cs;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_cs, mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs, mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: byte-wise block copy inside a single-port synchronous RAM.
// Each byte is a RD cycle followed by a WR cycle. The read data comes back
// registered by the RAM and is passed straight through to the write bus.
// Optional feature macro: MEM_COPY_DMA_FILL_EN adds fill_mode/fill_val. In fill
// mode the engine skips RD and writes fill_val to consecutive addresses.
module mem_copy_dma #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
`ifdef MEM_COPY_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_val,
`endif
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  remaining,
    mem_copy_dma_if.master    mem
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic              fill_q;

`ifdef MEM_COPY_DMA_FILL_EN
    logic [DATA_W-1:0] fill_val_q;

    // Capture the fill byte with each accepted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_val_q <= '0;
        end else if (state == IDLE && start) begin
            fill_val_q <= fill_val;
        end
    end

    // Write data: fill byte in fill mode, otherwise RAM read data; zero when not writing.
    assign mem.mem_wdata = !mem.mem_we ? '0 : (fill_q ? fill_val_q : mem.mem_rdata);
`else
    // Write data is the RAM read data passed through; zero when not writing.
    assign mem.mem_wdata = mem.mem_we ? mem.mem_rdata : '0;
`endif

    // Control FSM; strobes and address are registered alongside the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            fill_q       <= 1'b0;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            mem.mem_cs   <= 1'b0;
            mem.mem_re   <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        aborted   <= 1'b0;
                        busy      <= 1'b1;
                        remaining <= len;
`ifdef MEM_COPY_DMA_FILL_EN
                        fill_q    <= fill_mode;
`else
                        fill_q    <= 1'b0;
`endif
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            src_ptr    <= src_addr;
                            dst_ptr    <= dst_addr;
                            mem.mem_cs <= 1'b1;
`ifdef MEM_COPY_DMA_FILL_EN
                            if (fill_mode) begin
                                state        <= WR;
                                mem.mem_we   <= 1'b1;
                                mem.mem_addr <= dst_addr;
                            end else begin
                                state        <= RD;
                                mem.mem_re   <= 1'b1;
                                mem.mem_addr <= src_addr;
                            end
`else
                            state        <= RD;
                            mem.mem_re   <= 1'b1;
                            mem.mem_addr <= src_addr;
`endif
                        end
                    end
                end
                RD: begin
                    mem.mem_re <= 1'b0;
                    if (abort) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        aborted      <= 1'b1;
                        mem.mem_cs   <= 1'b0;
                        mem.mem_addr <= '0;
                    end else begin
                        state        <= WR;
                        mem.mem_we   <= 1'b1;
                        mem.mem_addr <= dst_ptr;
                    end
                end
                WR: begin
                    src_ptr   <= src_ptr + ADDR_W'(1);
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
                    if (abort || remaining == LEN_W'(1)) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        mem.mem_cs   <= 1'b0;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= '0;
                        if (abort) begin
                            aborted <= 1'b1;
                        end
                    end else if (fill_q) begin
                        mem.mem_addr <= dst_ptr + ADDR_W'(1);
                    end else begin
                        state        <= RD;
                        mem.mem_we   <= 1'b0;
                        mem.mem_re   <= 1'b1;
                        mem.mem_addr <= src_ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: table of directed jobs, randomized jobs,
// a mid-copy reset sequence and (with MEM_COPY_DMA_FILL_EN) a fill job.
// The expected RAM image is kept as a separate array and updated per job by a
// plain forward byte-copy loop.
module tb_mem_copy_dma;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, aborted;
    logic [LW-1:0] remaining;
`ifdef MEM_COPY_DMA_FILL_EN
    logic          fill_mode = 1'b0;
    logic [DW-1:0] fill_val = '0;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ram   [65536];
    logic [DW-1:0] model [65536];
    logic [DW-1:0] rdata;
    logic          ram_init = 1'b0;

    mem_copy_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .abort     (abort),
`ifdef MEM_COPY_DMA_FILL_EN
        .fill_mode (fill_mode),
        .fill_val  (fill_val),
`endif
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_byte(input int i);
        if (i >= 16 && i < 20) return DW'(8'h11 * (i - 15));
        return DW'((i * 37) ^ (i >> 8) ^ 8'h5a);
    endfunction

    // Synchronous RAM with registered read; contents loaded on the first edge.
    always_ff @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
            ram_init <= 1'b1;
        end else if (bus.mem_cs && bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_cs && bus.mem_re) rdata <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n);
        logic [AW-1:0] s, d;
        s = src;
        d = dst;
        for (int i = 0; i < n; i++) begin
            model[d] = model[s];
            s = s + AW'(1);
            d = d + AW'(1);
        end
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== model[i]) bad++;
        chk(name, bad, 0);
    endtask

    // Runs one job starting at a negedge in IDLE; abort_cyc is the 1-based busy
    // cycle during which abort is held (0 = never).
    task automatic run_job(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [LW-1:0] l, input int abort_cyc, input bit abort_at_start,
                           input int exp_done, input logic [LW-1:0] exp_rem, input bit exp_ab);
        int done_c;
        int nbytes;
        logic pat_ok;
        logic [AW-1:0] ea;
        src_addr = src;
        dst_addr = dst;
        len      = l;
        start    = 1'b1;
        abort    = abort_at_start;
        @(posedge clk);
        done_c = 0;
        pat_ok = 1'b1;
        for (int c = 1; c <= 2 * int'(l) + 4; c++) begin
            @(negedge clk);
            start    = 1'b0;
            abort    = 1'b0;
            src_addr = AW'($urandom);
            dst_addr = AW'($urandom);
            len      = LW'($urandom);
            if (done) begin
                done_c = c;
                break;
            end
            if (busy !== 1'b1 || bus.mem_cs !== 1'b1) pat_ok = 1'b0;
            if (c % 2 == 1) begin
                ea = src + AW'((c - 1) / 2);
                if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== ea) pat_ok = 1'b0;
            end else begin
                ea = dst + AW'(c / 2 - 1);
                if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== ea) pat_ok = 1'b0;
            end
            if (c == abort_cyc) abort = 1'b1;
            if (c == 3) begin
                start = 1'b1;
                len   = LW'(1);
            end
        end
        chk({tag, "_done_cycle"}, done_c, exp_done);
        chk({tag, "_bus_pattern"}, pat_ok, 1);
        chk({tag, "_aborted"}, aborted, exp_ab);
        chk({tag, "_remaining"}, remaining, exp_rem);
        chk({tag, "_done_strobes"}, {busy, bus.mem_cs, bus.mem_re, bus.mem_we}, 4'b1000);
        @(negedge clk);
        chk({tag, "_idle"}, {done, busy, bus.mem_cs, aborted}, {3'b000, exp_ab});
        if (l == 0) nbytes = 0;
        else if (abort_cyc >= 1 && abort_cyc <= 2 * int'(l)) nbytes = abort_cyc / 2;
        else nbytes = int'(l);
        model_copy(src, dst, nbytes);
        mem_check({tag, "_mem"});
    endtask

`ifdef MEM_COPY_DMA_FILL_EN
    task automatic run_fill();
        int done_c;
        logic ok;
        done_c    = 0;
        ok        = 1'b1;
        dst_addr  = 16'h0200;
        len       = 3;
        fill_mode = 1'b1;
        fill_val  = 8'hA5;
        start     = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start     = 1'b0;
            fill_mode = 1'b0;
            fill_val  = DW'($urandom);
            if (done) begin
                done_c = c;
                break;
            end
            if (bus.mem_cs !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b1 ||
                bus.mem_addr !== 16'h0200 + AW'(c - 1) || bus.mem_wdata !== 8'hA5) ok = 1'b0;
        end
        chk("fill_done_cycle", done_c, 4);
        chk("fill_pattern", ok, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) model[16'h0200 + i] = 8'hA5;
        mem_check("fill_mem");
    endtask
`endif

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        int            abort_cyc;
        bit            abort_at_start;
        int            exp_done;
        logic [LW-1:0] exp_rem;
        bit            exp_ab;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [AW-1:0] s, d;
        logic [LW-1:0] l;
        int ac;

        tbl[0] = '{16'h0010, 16'h0040, 16'd4, 0, 1'b0, 9, 16'd0, 1'b0};
        tbl[1] = '{16'h1234, 16'h2345, 16'd0, 0, 1'b0, 1, 16'd0, 1'b0};
        tbl[2] = '{16'hFFFE, 16'h0100, 16'd4, 0, 1'b0, 9, 16'd0, 1'b0};
        tbl[3] = '{16'h0300, 16'h0400, 16'd8, 6, 1'b0, 7, 16'd5, 1'b1};
        tbl[4] = '{16'h0800, 16'h0900, 16'd5, 3, 1'b0, 4, 16'd4, 1'b1};
        tbl[5] = '{16'h0A00, 16'h0A01, 16'd6, 0, 1'b0, 13, 16'd0, 1'b0};
        tbl[6] = '{16'h0B00, 16'h0C00, 16'd2, 0, 1'b1, 5, 16'd0, 1'b0};
        tbl[7] = '{16'h0D00, 16'hFFFF, 16'd1, 0, 1'b0, 3, 16'd0, 1'b0};
        tbl[8] = '{16'h0E00, 16'h0F00, 16'd3, 6, 1'b0, 7, 16'd0, 1'b1};
        tbl[9] = '{16'h3000, 16'h3100, 16'd0, 0, 1'b0, 1, 16'd0, 1'b0};

        for (int i = 0; i < 65536; i++) model[i] = init_byte(i);

        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, aborted, bus.mem_cs, bus.mem_re, bus.mem_we}, 0);
        chk("reset_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("reset_remaining", remaining, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, bus.mem_cs}, 0);

        for (int i = 0; i < 10; i++)
            run_job($sformatf("vec%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].abort_cyc,
                    tbl[i].abort_at_start, tbl[i].exp_done, tbl[i].exp_rem, tbl[i].exp_ab);

        // Reset asserted during the second RD of a 6-byte copy.
        src_addr = 16'h0500;
        dst_addr = 16'h0600;
        len      = 6;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_rd", {bus.mem_cs, bus.mem_re, bus.mem_we}, 3'b110);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_strobes", {busy, done, bus.mem_cs, bus.mem_re, bus.mem_we}, 0);
        chk("rst_addr_rem", {bus.mem_addr, remaining}, 0);
        model_copy(16'h0500, 16'h0600, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_check("rst_mem");
        run_job("post_rst", 16'h0500, 16'h0700, 16'd6, 0, 1'b0, 13, 16'd0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            s = AW'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + AW'($urandom_range(1, 3)) : AW'($urandom);
            l = LW'($urandom_range(0, 10));
            ac = ($urandom_range(0, 3) == 0 && l != 0) ? int'($urandom_range(1, 2 * int'(l))) : 0;
            if (l == 0)
                run_job($sformatf("rnd%0d", r), s, d, l, 0, 1'b0, 1, 16'd0, 1'b0);
            else if (ac != 0)
                run_job($sformatf("rnd%0d", r), s, d, l, ac, 1'b0, ac + 1, l - LW'(ac / 2), 1'b1);
            else
                run_job($sformatf("rnd%0d", r), s, d, l, 0, 1'b0, 2 * int'(l) + 1, 16'd0, 1'b0);
        end

`ifdef MEM_COPY_DMA_FILL_EN
        run_fill();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Bus initiator that drives the single-port synchronous RAM's `chipsel`/`readEn`/`writeEn`/`addrIn`/`busIn`/`busOut` interface. It copies a block of bytes from a source address range to a destination range inside the same RAM, one byte per read/write pair. Control logic starts it with a pulse and observes `busy`/`done`. It sits between the control logic and the RAM and owns the RAM port while `busy` is high.

## Interface
- `ADDR_W`, 16: width of `mem_addr`, `src_addr`, `dst_addr`; matches RAM `addrIn`.
- `DATA_W`, 8: width of the RAM data bus.
- `LEN_W`, 16: width of the byte-count operand.
- `clk`  in  1  single clock; everything samples on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source byte address; latched on accepted `start`.
- `dst_addr`  in  ADDR_W  first destination byte address; latched on accepted `start`.
- `len`  in  LEN_W  byte count; latched on accepted `start`.
- `abort`  in  1  stop request; honoured in RD/WR.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at completion or abort.
- `aborted`  out  1  set with `done` when ended by `abort`; held until next accepted `start`.
- `remaining`  out  LEN_W  bytes still to copy.
- `mem_cs`, `mem_re`, `mem_we`  out  1  to RAM `chipsel`, `readEn`, `writeEn`.
- `mem_addr`  out  ADDR_W  to RAM `addrIn`.
- `mem_wdata`  out  DATA_W  to RAM `busIn`.
- `mem_rdata`  in  DATA_W  from RAM `busOut`. Registered in the RAM: valid the cycle after the read is issued.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: all `mem_*` strobes are 0.
  - `start`=1 with `len`≠0: latch `src_ptr`, `dst_ptr` and `remaining`=`len`; clear `aborted`; go to RD.
  - `start`=1 with `len`=0: go to DONE. No RAM access occurs.
- RD: `mem_cs`=1, `mem_re`=1, `mem_we`=0, `mem_addr`=`src_ptr`. Next state is WR.
- WR: `mem_cs`=1, `mem_we`=1, `mem_re`=0, `mem_addr`=`dst_ptr`, `mem_wdata`=`mem_rdata` (combinational pass-through).
  - At the end of WR: `src_ptr`+1, `dst_ptr`+1, `remaining`−1.
  - Go to DONE if `remaining` was 1, else RD.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Outputs decode from state and pointer flops only; no path from `start` to `mem_*`.
- Pointers wrap modulo 2^ADDR_W; there is no range error.
- Copy runs strictly forward, byte by byte. If the ranges overlap with `dst`>`src`, the source pattern is replicated. This is defined behaviour.
- Abort:
  - `abort`=1 sampled at the end of RD or WR: the access on the bus that cycle still completes.
  - Next state is DONE and `aborted`=1.
  - Pointer/`remaining` update applies only if the aborted cycle was WR.
  - `abort` in IDLE/DONE is ignored.
- `start` while `busy` is ignored.
- Simultaneous `start` and `abort` in IDLE: start is accepted, abort is ignored.

## Timing
- Reset values (async, immediate): state IDLE; `busy`, `done`, `aborted`, `mem_cs`, `mem_re`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `remaining` = 0.
- `start` accepted at edge k: first RD in cycle k+1, first WR in cycle k+2.
- Each byte takes 2 cycles. `done` is high in cycle k+2·len+1. `busy` is high from cycle k+1 through the `done` cycle.
- `len`=0: `done` in cycle k+1, `busy` high only that cycle.
- Back-to-back: `start` is accepted in the first IDLE cycle after DONE, so at least 1 idle cycle separates jobs.
- Reset asserted mid-job drops all strobes at once. The RAM content written so far remains; no partial-byte corruption beyond the in-flight write edge.

## Configuration
- `MEM_COPY_DMA_FILL_EN` defined adds two inputs: `fill_mode` (1) and `fill_val` (DATA_W), latched on `start`.
  - `fill_mode`=1 skips RD: the FSM stays in WR, writing `fill_val` to `dst_ptr` every cycle for `len` cycles.
  - `done` then comes in cycle k+len+1.
- Macro undefined: those ports do not exist and every job is a copy.

## Test plan
- Copy: RAM[0x10..0x13]=11,22,33,44; start src=0x10 dst=0x40 len=4 → RAM[0x40..0x43]=11,22,33,44; `done` exactly 9 cycles after start edge; strobes alternate re/we.
- Zero length: start len=0 → `done` next cycle, `mem_cs` never 1, RAM unchanged.
- Wrap: src=0xFFFE dst=0x0100 len=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order; 4 bytes land at 0x0100..0x0103.
- Abort: len=8, assert `abort` during the 3rd WR → exactly 3 bytes written, `done`+`aborted`=1, `remaining`=5; a second `start` while busy is ignored.
- Reset mid-copy: drop `rst_n` during RD → all strobes 0 immediately, `busy`=0; after release a fresh copy completes correctly.
- Fill (`MEM_COPY_DMA_FILL_EN`): fill_mode=1 fill_val=0xA5 dst=0x200 len=3 → RAM[0x200..0x202]=A5, `mem_re` never 1, `done` at k+4.
